// File: rtl/spgd_metric_diff.sv
// Two-sided SPGD metric sequencer: measures J+ and J- under opposite perturbations
// and emits the saturated, arithmetically scaled difference (J+ - J-) >>> GAIN_SHIFT.
module spgd_metric_diff #(
    parameter int FLOAT_WIDTH   = 64,
    parameter int GAIN_SHIFT    = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                   ADC_CLK,
    input  logic                   RSTN,
    input  logic                   START,
    input  logic                   ABORT,
    input  logic [FLOAT_WIDTH-1:0] METRIC_IN,
    input  logic                   METRIC_WRITE,
    output logic                   ADC_ENABLE,
    output logic                   PERTURB_SIGN,
    output logic [FLOAT_WIDTH-1:0] DELTA_OUT,
    output logic                   DELTA_VALID,
    output logic                   BUSY,
    output logic                   OVERFLOW
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [FLOAT_WIDTH-1:0] POS_MAX = {1'b0, {(FLOAT_WIDTH-1){1'b1}}};
    localparam logic [FLOAT_WIDTH-1:0] NEG_MIN = {1'b1, {(FLOAT_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE_P, S_MEAS_P, S_SETTLE_M, S_MEAS_M, S_CALC, S_OUT
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [FLOAT_WIDTH-1:0] j_plus_q, j_plus_d;
    logic [FLOAT_WIDTH-1:0] j_minus_q, j_minus_d;
    logic [FLOAT_WIDTH-1:0] result_q, result_d;
    logic                   result_sat_q, result_sat_d;
    logic [FLOAT_WIDTH-1:0] delta_q, delta_d;
    logic                   valid_q, valid_d;
    logic                   adc_en_q, adc_en_d;
    logic                   sign_q, sign_d;
    logic                   busy_q, busy_d;
    logic                   ovf_q, ovf_d;

    logic signed [FLOAT_WIDTH:0] diff, shifted;
    logic                        sat_hi, sat_lo;
    logic [FLOAT_WIDTH-1:0]      clamped;

    always_comb begin
        diff    = $signed({1'b0, j_plus_q}) - $signed({1'b0, j_minus_q});
        shifted = diff >>> GAIN_SHIFT;
        // Fits in FLOAT_WIDTH bits only when the top two bits agree.
        sat_hi  = !shifted[FLOAT_WIDTH] && shifted[FLOAT_WIDTH-1];
        sat_lo  = shifted[FLOAT_WIDTH] && !shifted[FLOAT_WIDTH-1];
        if (sat_hi)      clamped = POS_MAX;
        else if (sat_lo) clamped = NEG_MIN;
        else             clamped = shifted[FLOAT_WIDTH-1:0];
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        j_plus_d     = j_plus_q;
        j_minus_d    = j_minus_q;
        result_d     = result_q;
        result_sat_d = result_sat_q;
        delta_d      = delta_q;
        valid_d      = 1'b0;
        adc_en_d     = adc_en_q;
        sign_d       = sign_q;
        busy_d       = busy_q;
        ovf_d        = ovf_q;

        if (ABORT && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            adc_en_d = 1'b0;
            sign_d   = 1'b0;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: if (START && !ABORT) begin
                    state_d = S_SETTLE_P;
                    sign_d  = 1'b1;
                    busy_d  = 1'b1;
                    ovf_d   = 1'b0;
                    cnt_d   = SETTLE_LOAD;
                end
                S_SETTLE_P, S_SETTLE_M: begin
                    if (cnt_q == '0) begin
                        state_d  = (state_q == S_SETTLE_P) ? S_MEAS_P : S_MEAS_M;
                        adc_en_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_MEAS_P: if (METRIC_WRITE) begin
                    j_plus_d = METRIC_IN;
                    state_d  = S_SETTLE_M;
                    adc_en_d = 1'b0;
                    sign_d   = 1'b0;
                    cnt_d    = SETTLE_LOAD;
                end
                S_MEAS_M: if (METRIC_WRITE) begin
                    j_minus_d = METRIC_IN;
                    state_d   = S_CALC;
                    adc_en_d  = 1'b0;
                end
                S_CALC: begin
                    result_d     = clamped;
                    result_sat_d = sat_hi || sat_lo;
                    state_d      = S_OUT;
                end
                // Result is staged so DELTA_OUT, DELTA_VALID and OVERFLOW update together.
                S_OUT: begin
                    delta_d = result_q;
                    ovf_d   = result_sat_q;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ADC_CLK) begin
        if (!RSTN) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            j_plus_q     <= '0;
            j_minus_q    <= '0;
            result_q     <= '0;
            result_sat_q <= 1'b0;
            delta_q      <= '0;
            valid_q      <= 1'b0;
            adc_en_q     <= 1'b0;
            sign_q       <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            j_plus_q     <= j_plus_d;
            j_minus_q    <= j_minus_d;
            result_q     <= result_d;
            result_sat_q <= result_sat_d;
            delta_q      <= delta_d;
            valid_q      <= valid_d;
            adc_en_q     <= adc_en_d;
            sign_q       <= sign_d;
            busy_q       <= busy_d;
            ovf_q        <= ovf_d;
        end
    end

    assign ADC_ENABLE   = adc_en_q;
    assign PERTURB_SIGN = sign_q;
    assign DELTA_OUT    = delta_q;
    assign DELTA_VALID  = valid_q;
    assign BUSY         = busy_q;
    assign OVERFLOW     = ovf_q;

endmodule

// File: tb/tb_spgd_metric_diff.sv
// Bench for spgd_metric_diff: two instances (GAIN_SHIFT 4 and 0) share stimulus and are
// checked cycle by cycle against expected sequencing and a floor-division result model.
module tb_spgd_metric_diff;

    localparam int S = 16;

    logic        clk = 1'b0;
    logic        rstn, start, abort, mw;
    logic [63:0] min;
    logic        a_en, a_sign, a_valid, a_busy, a_ovf;
    logic        b_en, b_sign, b_valid, b_busy, b_ovf;
    logic [63:0] a_delta, b_delta;
    logic [63:0] prev_a = '0, prev_b = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spgd_metric_diff #(.FLOAT_WIDTH(64), .GAIN_SHIFT(4), .SETTLE_CYCLES(S)) dut_a (
        .ADC_CLK(clk), .RSTN(rstn), .START(start), .ABORT(abort),
        .METRIC_IN(min), .METRIC_WRITE(mw), .ADC_ENABLE(a_en), .PERTURB_SIGN(a_sign),
        .DELTA_OUT(a_delta), .DELTA_VALID(a_valid), .BUSY(a_busy), .OVERFLOW(a_ovf));

    spgd_metric_diff #(.FLOAT_WIDTH(64), .GAIN_SHIFT(0), .SETTLE_CYCLES(S)) dut_b (
        .ADC_CLK(clk), .RSTN(rstn), .START(start), .ABORT(abort),
        .METRIC_IN(min), .METRIC_WRITE(mw), .ADC_ENABLE(b_en), .PERTURB_SIGN(b_sign),
        .DELTA_OUT(b_delta), .DELTA_VALID(b_valid), .BUSY(b_busy), .OVERFLOW(b_ovf));

    typedef struct {
        logic [63:0] jp, jm;
        int          rp, rm;
        bit          stray;
        logic [63:0] ea;
        bit          oa;
        logic [63:0] eb;
        bit          ob;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        bit          o;
    } res_t;

    // Reference: floor((J+ - J-) / 2^shift), clamped to the signed 64-bit range.
    function automatic res_t model(input logic [63:0] jp, input logic [63:0] jm, input int shift);
        logic signed [127:0] d, q, den, hi, lo;
        res_t r;
        d   = $signed({64'b0, jp}) - $signed({64'b0, jm});
        den = 128'sd1 <<< shift;
        if (d >= 0) q = d / den;
        else        q = -((-d + den - 128'sd1) / den);
        hi = (128'sd1 <<< 63) - 128'sd1;
        lo = -(128'sd1 <<< 63);
        if (q > hi)      begin r.d = hi[63:0]; r.o = 1'b1; end
        else if (q < lo) begin r.d = lo[63:0]; r.o = 1'b1; end
        else             begin r.d = q[63:0];  r.o = 1'b0; end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic en, input logic sign, input logic busy);
        chk({tag, " a_en"},   64'(a_en),   64'(en));
        chk({tag, " b_en"},   64'(b_en),   64'(en));
        chk({tag, " a_sign"}, 64'(a_sign), 64'(sign));
        chk({tag, " b_sign"}, 64'(b_sign), 64'(sign));
        chk({tag, " a_busy"}, 64'(a_busy), 64'(busy));
        chk({tag, " b_busy"}, 64'(b_busy), 64'(busy));
    endtask

    task automatic chk_valid(input string tag, input logic v);
        chk({tag, " a_valid"}, 64'(a_valid), 64'(v));
        chk({tag, " b_valid"}, 64'(b_valid), 64'(v));
    endtask

    task automatic settle(input string tag, input logic sign, input bit stray);
        for (int i = 1; i <= S; i++) begin
            if (stray && i == 2) begin
                mw = 1'b1; min = {$urandom, $urandom}; start = 1'b1;
            end
            tick;
            mw = 1'b0; start = 1'b0;
            chk_ctl(tag, logic'(i == S), sign, 1'b1);
            chk_valid(tag, 1'b0);
        end
    endtask

    task automatic meas(input string tag, input logic sign, input int resp,
                        input logic [63:0] val, input bit stray);
        for (int r = 0; r < resp; r++) begin
            if (stray) start = 1'b1;
            tick;
            start = 1'b0;
            chk_ctl(tag, 1'b1, sign, 1'b1);
        end
        mw = 1'b1; min = val;
        tick;
        mw = 1'b0; min = {$urandom, $urandom};
        chk_ctl({tag, "_strobe"}, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic start_seq;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk_ctl("start", 1'b0, 1'b1, 1'b1);
        chk("ovf_clear a", 64'(a_ovf), 64'd0);
        chk("ovf_clear b", 64'(b_ovf), 64'd0);
    endtask

    task automatic run_pair(input vec_t t);
        if (t.stray) begin
            mw = 1'b1; min = {$urandom, $urandom};
            tick;
            mw = 1'b0;
            chk_ctl("idle_stray", 1'b0, 1'b0, 1'b0);
        end
        start_seq;
        settle("settle_p", 1'b1, t.stray);
        meas("meas_p", 1'b1, t.rp, t.jp, t.stray);
        settle("settle_m", 1'b0, t.stray);
        meas("meas_m", 1'b0, t.rm, t.jm, t.stray);
        chk_valid("jm_edge", 1'b0);
        if (t.stray) mw = 1'b1;
        tick;
        mw = 1'b0;
        chk_ctl("calc", 1'b0, 1'b0, 1'b1);
        chk_valid("calc", 1'b0);
        tick;
        chk_ctl("out", 1'b0, 1'b0, 1'b0);
        chk_valid("out", 1'b1);
        chk("delta a", a_delta, t.ea);
        chk("delta b", b_delta, t.eb);
        chk("ovf a", 64'(a_ovf), 64'(t.oa));
        chk("ovf b", 64'(b_ovf), 64'(t.ob));
        prev_a = t.ea;
        prev_b = t.eb;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk_valid("post", 1'b0);
            chk("hold a", a_delta, prev_a);
            chk("hold b", b_delta, prev_b);
        end
    endtask

    vec_t v[12];

    initial begin
        res_t ra, rb;
        v[0] = '{64'h0001_8000_0000_0000, 64'h0001_0000_0000_0000, 0, 0, 1'b0,
                 64'h0000_0800_0000_0000, 1'b0, 64'h0000_8000_0000_0000, 1'b0};
        v[1] = '{64'h0001_0000_0000_0000, 64'h0001_8000_0000_0000, 1, 2, 1'b0,
                 64'hFFFF_F800_0000_0000, 1'b0, 64'hFFFF_8000_0000_0000, 1'b0};
        v[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 1, 1'b0,
                 64'h0FFF_FFFF_FFFF_FFFF, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
        v[3] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0, 1'b0,
                 64'hF000_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 1'b1};
        v[4] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 2, 3, 1'b1,
                 64'h0, 1'b0, 64'h0, 1'b0};
        v[5] = '{64'h0, 64'h1, 0, 0, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        for (int i = 6; i < 12; i++) begin
            v[i].jp    = {$urandom, $urandom};
            v[i].jm    = (i == 7) ? {1'b0, v[i].jp[63:1]} : {$urandom, $urandom};
            v[i].rp    = int'($urandom_range(0, 3));
            v[i].rm    = int'($urandom_range(0, 3));
            v[i].stray = 1'(i % 2);
            ra = model(v[i].jp, v[i].jm, 4);
            rb = model(v[i].jp, v[i].jm, 0);
            v[i].ea = ra.d; v[i].oa = ra.o;
            v[i].eb = rb.d; v[i].ob = rb.o;
        end

        rstn = 1'b0; start = 1'b0; abort = 1'b0; mw = 1'b0; min = '0;
        tick; tick;
        rstn = 1'b1;
        tick;
        chk_ctl("reset", 1'b0, 1'b0, 1'b0);
        chk_valid("reset", 1'b0);
        chk("reset delta a", a_delta, 64'd0);
        chk("reset delta b", b_delta, 64'd0);
        chk("reset ovf a", 64'(a_ovf), 64'd0);
        chk("reset ovf b", 64'(b_ovf), 64'd0);

        for (int i = 0; i < 6; i++) run_pair(v[i]);

        // ABORT coincident with the J- strobe.
        start_seq;
        settle("ab_settle_p", 1'b1, 1'b0);
        meas("ab_meas_p", 1'b1, 0, {$urandom, $urandom}, 1'b0);
        settle("ab_settle_m", 1'b0, 1'b0);
        abort = 1'b1; mw = 1'b1; min = {$urandom, $urandom};
        tick;
        abort = 1'b0; mw = 1'b0;
        chk_ctl("abort", 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk_valid("abort", 1'b0);
            chk("abort hold a", a_delta, prev_a);
            chk("abort hold b", b_delta, prev_b);
            tick;
        end

        // ABORT beats START in IDLE.
        start = 1'b1; abort = 1'b1;
        tick;
        start = 1'b0; abort = 1'b0;
        chk_ctl("abort_start", 1'b0, 1'b0, 1'b0);
        tick;
        chk_ctl("abort_start2", 1'b0, 1'b0, 1'b0);

        // Reset during SETTLE_M.
        start_seq;
        settle("rs_settle_p", 1'b1, 1'b0);
        meas("rs_meas_p", 1'b1, 1, {$urandom, $urandom}, 1'b0);
        tick; tick; tick;
        rstn = 1'b0;
        tick;
        chk_ctl("midreset", 1'b0, 1'b0, 1'b0);
        chk_valid("midreset", 1'b0);
        chk("midreset delta a", a_delta, 64'd0);
        chk("midreset delta b", b_delta, 64'd0);
        chk("midreset ovf a", 64'(a_ovf), 64'd0);
        chk("midreset ovf b", 64'(b_ovf), 64'd0);
        rstn = 1'b1;
        tick;
        chk_valid("after_reset", 1'b0);
        prev_a = '0; prev_b = '0;

        for (int i = 6; i < 12; i++) run_pair(v[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
